// File: rtl/quantum_scheduler_pkg.sv
// sched_pkg: types and default constants for the quantum scheduler.
//   sched_state_t : scheduler FSM state encoding
//   PROG_W        : width of a program slot index for the default slot count
package sched_pkg;

  localparam int NUM_PROGS_DEF       = 4;
  localparam int QW_DEF              = 16;
  localparam int DEFAULT_QUANTUM_DEF = 100;
  localparam int PROG_W              = $clog2(NUM_PROGS_DEF);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    SAVE   = 3'd2,
    LOAD   = 3'd3,
    RUN    = 3'd4
  } sched_state_t;

endpackage

// File: rtl/quantum_scheduler_if.sv
// quantum_scheduler_if: event/handshake bundle between the control unit,
// the PC / data-RAM context logic and the quantum scheduler.
//   slave  : scheduler side (events and acks in, requests and status out)
//   master : control / datapath side
interface quantum_scheduler_if
  import sched_pkg::*;
#(
  parameter int NUM_PROGS = NUM_PROGS_DEF,
  parameter int QW        = QW_DEF
);
  localparam int PW = $clog2(NUM_PROGS);

  logic                 instr_tick;
  logic                 def_quantum;
  logic [QW-1:0]        quantum_value;
  logic                 end_program;
  logic                 start_prog;
  logic [PW-1:0]        start_id;
  logic                 save_ack;
  logic                 load_ack;

  logic                 save_req;
  logic                 load_req;
  logic                 change_program;
  logic [PW-1:0]        cur_prog;
  logic                 running;
  logic                 idle;
  logic [NUM_PROGS-1:0] ready_mask;

  modport slave (
    input  instr_tick, def_quantum, quantum_value, end_program,
           start_prog, start_id, save_ack, load_ack,
    output save_req, load_req, change_program, cur_prog, running,
           idle, ready_mask
  );

  modport master (
    output instr_tick, def_quantum, quantum_value, end_program,
           start_prog, start_id, save_ack, load_ack,
    input  save_req, load_req, change_program, cur_prog, running,
           idle, ready_mask
  );

endinterface

// File: rtl/quantum_scheduler_rr_picker.sv
// rr_picker: combinational round-robin search.
//   mask_i  : request bit per slot
//   start_i : first slot examined; search wraps and ends at start_i-1
//   hit_o   : some bit of mask_i is set
//   idx_o   : first set slot at or after start_i (start_i when no hit)
// N must be a power of two so the index wraps naturally.
module rr_picker
  import sched_pkg::*;
#(
  parameter int N = NUM_PROGS_DEF,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] mask_i,
  input  logic [W-1:0] start_i,
  output logic         hit_o,
  output logic [W-1:0] idx_o
);

  logic [W-1:0] pos;

  // Walk from the farthest offset down to zero so the nearest hit wins.
  always_comb begin
    hit_o = 1'b0;
    idx_o = start_i;
    pos   = start_i;
    for (int k = N - 1; k >= 0; k--) begin
      pos = start_i + W'(k);
      if (mask_i[pos]) begin
        hit_o = 1'b1;
        idx_o = pos;
      end
    end
  end

endmodule

// File: rtl/quantum_scheduler.sv
// quantum_scheduler: round-robin time-slice scheduler.
// Counts retired instructions of the running program, preempts it when its
// quantum expires, sequences context save / load with the PC and data RAM,
// and reports the active slot.
//   clock : system clock
//   reset : asynchronous active-low reset
//   bus   : quantum_scheduler_if.slave (events/acks in, requests/status out)
//
// state  | meaning
// IDLE   | no slot ready, parked
// SELECT | round-robin search starting after cur_prog
// LOAD   | load_req held until load_ack
// RUN    | program running, counting instr_tick
// SAVE   | save_req held until save_ack
module quantum_scheduler
  import sched_pkg::*;
#(
  parameter int NUM_PROGS       = NUM_PROGS_DEF,
  parameter int QW              = QW_DEF,
  parameter int DEFAULT_QUANTUM = DEFAULT_QUANTUM_DEF
) (
  input logic                 clock,
  input logic                 reset,
  quantum_scheduler_if.slave  bus
);

  localparam int PW = $clog2(NUM_PROGS);

  sched_state_t         state_q, state_d;
  logic [PW-1:0]        cur_q, cur_d;
  logic [NUM_PROGS-1:0] ready_q, ready_d;
  logic [QW-1:0]        quantum_q, quantum_d;
  logic [QW-1:0]        count_q, count_d;
  logic                 save_req_q, save_req_d;
  logic                 load_req_q, load_req_d;
  logic                 chg_q, chg_d;
  logic                 running_q, idle_q;

  logic [QW-1:0]        new_quantum;
  logic [NUM_PROGS-1:0] cur_onehot;
  logic                 others_ready;
  logic                 pick_hit;
  logic [PW-1:0]        pick_idx;
  logic [PW-1:0]        pick_start;

  // A zero quantum would never expire; clamp it to one tick.
  assign new_quantum  = (bus.quantum_value == '0) ? QW'(1) : bus.quantum_value;
  // Reloads read quantum_d so a def_quantum in the reload cycle takes effect.
  assign quantum_d    = bus.def_quantum ? new_quantum : quantum_q;
  assign cur_onehot   = NUM_PROGS'(1) << cur_q;
  assign others_ready = |(ready_q & ~cur_onehot);
  assign pick_start   = cur_q + PW'(1);

  rr_picker #(.N(NUM_PROGS)) u_picker (
    .mask_i  (ready_q),
    .start_i (pick_start),
    .hit_o   (pick_hit),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    ready_d    = ready_q;
    count_d    = count_q;
    save_req_d = save_req_q;
    load_req_d = load_req_q;
    chg_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (|ready_q) state_d = SELECT;
      end
      SELECT: begin
        if (pick_hit) begin
          cur_d      = pick_idx;
          load_req_d = 1'b1;
          state_d    = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (bus.load_ack) begin
          load_req_d = 1'b0;
          count_d    = quantum_d;
          chg_d      = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        // end_program outranks a coincident expiry: the slot is gone, nothing to save.
        if (bus.end_program) begin
          ready_d = ready_q & ~cur_onehot;
          state_d = SELECT;
        end else if (bus.instr_tick) begin
          if (count_q == QW'(1)) begin
            if (others_ready) begin
              save_req_d = 1'b1;
              state_d    = SAVE;
            end else begin
              count_d = quantum_d;
            end
          end else begin
            count_d = count_q - QW'(1);
          end
        end
      end
      SAVE: begin
        if (bus.save_ack) begin
          save_req_d = 1'b0;
          state_d    = SELECT;
        end
      end
      default: state_d = IDLE;
    endcase

    // Applied last so a start on the slot being ended keeps it ready.
    if (bus.start_prog) ready_d[bus.start_id] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      ready_q    <= '0;
      quantum_q  <= QW'(DEFAULT_QUANTUM);
      count_q    <= QW'(DEFAULT_QUANTUM);
      save_req_q <= 1'b0;
      load_req_q <= 1'b0;
      chg_q      <= 1'b0;
      running_q  <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      ready_q    <= ready_d;
      quantum_q  <= quantum_d;
      count_q    <= count_d;
      save_req_q <= save_req_d;
      load_req_q <= load_req_d;
      chg_q      <= chg_d;
      running_q  <= (state_d == RUN);
      idle_q     <= (state_d == IDLE);
    end
  end

  assign bus.save_req       = save_req_q;
  assign bus.load_req       = load_req_q;
  assign bus.change_program = chg_q;
  assign bus.cur_prog       = cur_q;
  assign bus.running        = running_q;
  assign bus.idle           = idle_q;
  assign bus.ready_mask     = ready_q;

endmodule

// File: tb/tb_quantum_scheduler.sv
module tb_quantum_scheduler;
  import sched_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;

  quantum_scheduler_if #(.NUM_PROGS(4), .QW(16)) bus ();

  quantum_scheduler #(
    .NUM_PROGS       (4),
    .QW              (16),
    .DEFAULT_QUANTUM (100)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int         n_checks = 0;
  int         n_err    = 0;
  logic [1:0] sb_q[$];
  logic [1:0] sb_exp;
  logic [1:0] rr_exp[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      bus.instr_tick = 1'b1;
      cyc();
    end
    bus.instr_tick = 1'b0;
  endtask

  task automatic pulse_start(input int id);
    bus.start_prog = 1'b1;
    bus.start_id   = 2'(id);
    cyc();
    bus.start_prog = 1'b0;
  endtask

  task automatic end_p();
    bus.end_program = 1'b1;
    cyc();
    bus.end_program = 1'b0;
  endtask

  task automatic save_ack_p();
    bus.save_ack = 1'b1;
    cyc();
    bus.save_ack = 1'b0;
  endtask

  // Expected slot goes to the scoreboard; the monitor checks it on change_program.
  task automatic load_ack_p(input logic [1:0] exp_slot);
    sb_q.push_back(exp_slot);
    bus.load_ack = 1'b1;
    cyc();
    bus.load_ack = 1'b0;
    chk("running_after_load", 32'(bus.running), 1);
  endtask

  task automatic set_quantum(input int q);
    bus.def_quantum   = 1'b1;
    bus.quantum_value = 16'(q);
    cyc();
    bus.def_quantum   = 1'b0;
  endtask

  task automatic wait_load(input string tag);
    int i = 0;
    while (!bus.load_req && i < 20) begin
      cyc();
      i++;
    end
    chk(tag, 32'(bus.load_req), 1);
  endtask

  task automatic wait_idle(input string tag);
    int i = 0;
    while (!bus.idle && i < 20) begin
      cyc();
      i++;
    end
    chk(tag, 32'(bus.idle), 1);
  endtask

  always @(negedge clock) begin
    if (reset && bus.change_program) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_change", 32'(bus.change_program), 0);
      end else begin
        sb_exp = sb_q.pop_front();
        chk("sb_change_slot", 32'(bus.cur_prog), 32'(sb_exp));
      end
    end
  end

  initial begin
    bus.instr_tick    = 1'b0;
    bus.def_quantum   = 1'b0;
    bus.quantum_value = '0;
    bus.end_program   = 1'b0;
    bus.start_prog    = 1'b0;
    bus.start_id      = '0;
    bus.save_ack      = 1'b0;
    bus.load_ack      = 1'b0;
    rr_exp[0] = 2'd3;
    rr_exp[1] = 2'd0;
    rr_exp[2] = 2'd2;

    cyc(); cyc(); cyc();
    chk("rst_idle",     32'(bus.idle), 1);
    chk("rst_running",  32'(bus.running), 0);
    chk("rst_save_req", 32'(bus.save_req), 0);
    chk("rst_load_req", 32'(bus.load_req), 0);
    chk("rst_change",   32'(bus.change_program), 0);
    chk("rst_cur",      32'(bus.cur_prog), 0);
    chk("rst_ready",    32'(bus.ready_mask), 0);
    reset = 1'b1;
    cyc();

    // Single slot: default quantum expires with nobody else ready.
    pulse_start(0);
    wait_load("load_slot0");
    chk("cur_slot0", 32'(bus.cur_prog), 0);
    load_ack_p(2'd0);
    tick(99);
    chk("no_save_at_99", 32'(bus.save_req), 0);
    // Expiry with a coincident def_quantum: reload takes the new value (3).
    bus.def_quantum   = 1'b1;
    bus.quantum_value = 16'd3;
    tick(1);
    bus.def_quantum   = 1'b0;
    chk("no_save_alone", 32'(bus.save_req), 0);
    chk("still_running", 32'(bus.running), 1);

    // Two slots, quantum 3.
    pulse_start(1);
    chk("ready_01", 32'(bus.ready_mask), 32'h3);
    tick(2);
    chk("save_before_q", 32'(bus.save_req), 0);
    tick(1);
    chk("save_at_q", 32'(bus.save_req), 1);
    save_ack_p();
    chk("save_dropped", 32'(bus.save_req), 0);
    wait_load("load_slot1");
    chk("cur_slot1", 32'(bus.cur_prog), 1);
    load_ack_p(2'd1);
    tick(3);
    chk("save_slot1_exp", 32'(bus.save_req), 1);
    save_ack_p();
    wait_load("load_back0");
    chk("cur_back0", 32'(bus.cur_prog), 0);
    load_ack_p(2'd0);

    // End slot 0 while starting slot 2, then end slot 1 -> slot 2 runs alone.
    bus.end_program = 1'b1;
    bus.start_prog  = 1'b1;
    bus.start_id    = 2'd2;
    cyc();
    bus.end_program = 1'b0;
    bus.start_prog  = 1'b0;
    chk("end_no_save", 32'(bus.save_req), 0);
    chk("ready_12", 32'(bus.ready_mask), 32'h6);
    wait_load("load_after_end0");
    chk("cur_after_end0", 32'(bus.cur_prog), 1);
    load_ack_p(2'd1);
    end_p();
    wait_load("load_slot2");
    chk("cur_slot2", 32'(bus.cur_prog), 2);
    load_ack_p(2'd2);
    pulse_start(0);
    pulse_start(3);
    chk("ready_023", 32'(bus.ready_mask), 32'hD);
    for (int r = 0; r < 3; r++) begin
      tick(3);
      chk("rr_save", 32'(bus.save_req), 1);
      save_ack_p();
      wait_load("rr_load");
      chk("rr_order", 32'(bus.cur_prog), 32'(rr_exp[r]));
      load_ack_p(rr_exp[r]);
    end

    // End slot 2 -> slot 3; then end coincides with expiry on slot 3.
    end_p();
    wait_load("load_slot3");
    chk("cur_slot3", 32'(bus.cur_prog), 3);
    load_ack_p(2'd3);
    tick(2);
    bus.instr_tick  = 1'b1;
    bus.end_program = 1'b1;
    cyc();
    bus.instr_tick  = 1'b0;
    bus.end_program = 1'b0;
    chk("end_wins_no_save", 32'(bus.save_req), 0);
    chk("end_wins_ready", 32'(bus.ready_mask), 32'h1);
    wait_load("load_after_endexp");
    chk("cur_after_endexp", 32'(bus.cur_prog), 0);
    load_ack_p(2'd0);

    // End the only ready slot -> idle; restart with slot 1.
    end_p();
    chk("last_end_no_save", 32'(bus.save_req), 0);
    wait_idle("idle_after_last");
    chk("ready_empty", 32'(bus.ready_mask), 0);
    pulse_start(1);
    wait_load("load_from_idle");
    chk("cur_from_idle", 32'(bus.cur_prog), 1);
    load_ack_p(2'd1);

    // Start and end on the same slot: start wins, slot 1 is reselected.
    bus.end_program = 1'b1;
    bus.start_prog  = 1'b1;
    bus.start_id    = 2'd1;
    cyc();
    bus.end_program = 1'b0;
    bus.start_prog  = 1'b0;
    chk("start_wins_ready", 32'(bus.ready_mask), 32'h2);
    wait_load("load_reselect");
    chk("cur_reselect", 32'(bus.cur_prog), 1);
    load_ack_p(2'd1);

    // def_quantum mid-slice: current count of 3 unaffected, next slice 5, then 1.
    pulse_start(2);
    tick(1);
    set_quantum(5);
    tick(1);
    chk("midq_no_save", 32'(bus.save_req), 0);
    tick(1);
    chk("midq_save", 32'(bus.save_req), 1);
    save_ack_p();
    wait_load("load_q5");
    chk("cur_q5", 32'(bus.cur_prog), 2);
    load_ack_p(2'd2);
    set_quantum(0);
    tick(4);
    chk("q5_no_save", 32'(bus.save_req), 0);
    tick(1);
    chk("q5_save", 32'(bus.save_req), 1);
    save_ack_p();
    wait_load("load_q1");
    chk("cur_q1", 32'(bus.cur_prog), 1);
    load_ack_p(2'd1);
    tick(1);
    chk("q1_save", 32'(bus.save_req), 1);

    // Reset in SAVE drops the request asynchronously.
    #2;
    reset = 1'b0;
    #1;
    chk("arst_save_req", 32'(bus.save_req), 0);
    chk("arst_load_req", 32'(bus.load_req), 0);
    chk("arst_idle",     32'(bus.idle), 1);
    chk("arst_running",  32'(bus.running), 0);
    chk("arst_ready",    32'(bus.ready_mask), 0);
    cyc();
    reset = 1'b1;
    cyc();
    chk("sb_drained", 32'(sb_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/quantum_scheduler.md
# quantum_scheduler

Round-robin time-slice scheduler for the multi-program processor. It counts retired instructions of the running program, preempts it when its quantum expires, and sequences the context save (SPC) / context load (LPC) handshake with the PC and data-RAM context storage. It then selects the next ready program slot and reports the active slot to the datapath. It sits between the control unit (end/quantum events) and the PC/data-RAM context logic, replacing ad-hoc `changeProgram` sequencing.

## Interface
- `NUM_PROGS`, 4: number of program slots (power of two, ≥2)
- `QW`, 16: quantum counter width
- `DEFAULT_QUANTUM`, 100: quantum after reset
- `clock` in 1: system clock
- `reset` in 1: asynchronous, active-low reset
- `instr_tick` in 1: one-cycle pulse per retired instruction (already synchronous to `clock`)
- `def_quantum` in 1: load `quantum_value` into the quantum register
- `quantum_value` in QW: new quantum; 0 is treated as 1
- `end_program` in 1: running program executed its end instruction (pulse)
- `start_prog` in 1: mark slot `start_id` ready (pulse)
- `start_id` in log2(NUM_PROGS): slot to start
- `save_ack` in 1: context save complete (pulse)
- `load_ack` in 1: context load complete (pulse)
- `save_req` out 1: request SPC of `cur_prog`; held until `save_ack`
- `load_req` out 1: request LPC of `cur_prog`; held until `load_ack`
- `change_program` out 1: one-cycle pulse when the new program starts running
- `cur_prog` out log2(NUM_PROGS): active slot
- `running` out 1: high in RUN
- `idle` out 1: no slot ready, scheduler parked
- `ready_mask` out NUM_PROGS: ready bit per slot

## Operation
- States: IDLE, SELECT, SAVE, LOAD, RUN.
- IDLE: `idle`=1. Any set ready bit → SELECT next cycle.
- SELECT: round-robin search from `cur_prog`+1 (wrapping) through `cur_prog` inclusive. Hit → `cur_prog`←hit, `load_req`=1, go LOAD. No hit → IDLE.
- LOAD: hold `load_req`. On `load_ack`: drop `load_req`, reload counter with quantum, pulse `change_program`, go RUN.
- RUN: each `instr_tick` decrements the counter.
  - Tick at counter==1 is expiry.
  - If another slot is ready: `save_req`=1, go SAVE.
  - If no other slot is ready: reload counter, stay RUN, no save, no pulse.
- SAVE: hold `save_req`. On `save_ack` → SELECT; the search starts after the saved slot.
- `end_program` in RUN: clear ready bit of `cur_prog`, no save, go SELECT.
- Ready bits:
  - `start_prog` sets the bit in any state. Starting an already-ready slot has no effect.
  - Only `end_program` clears a bit.
- `def_quantum` updates the quantum register only. The new value applies at the next counter reload; the running count is unaffected.
- Acks outside their state are ignored. `instr_tick` outside RUN is ignored.

## Timing
- Reset values:
  - Outputs: state IDLE, `idle`=1, `running`=0, `save_req`=`load_req`=`change_program`=0, `cur_prog`=0.
  - Internal: ready bits 0, quantum=DEFAULT_QUANTUM, counter=DEFAULT_QUANTUM.
- Preemption latency:
  - Expiry tick at cycle N → `save_req` high at N+1.
  - `save_ack` at M → SELECT at M+1 → `load_req` at M+2.
  - `load_ack` at K → `change_program` pulse and `running` at K+1.
- All outputs are registered.
- Simultaneous events:
  - `end_program` and expiry tick in the same cycle: end wins (no save).
  - `start_prog` and `end_program` on the same slot: start wins, so the bit stays set, the slot is re-selectable, and SELECT still runs.
  - `def_quantum` coinciding with a reload: the reload uses the new value.
- Reset mid-handshake: requests drop asynchronously. The datapath must abandon the transfer.

## Structure
- `sched_pkg`: state enum `sched_state_t`, `PROG_W`=$clog2(NUM_PROGS), default constants.
- Sub-module `rr_picker`: combinational; inputs mask and start index; outputs hit flag and index. Reusable by other arbiters.
- Instantiated in the top level next to `PC` and `dados_RAM`. `change_program` feeds both.

## Test plan
- Reset, start slot 0, load_ack → `change_program` pulse, `cur_prog`=0, `running`=1; after 100 ticks with no other ready slot, no save, still running.
- Slots 0 and 1 ready, quantum=3 → after 3rd tick, `save_req`=1; save_ack, load_ack → `cur_prog`=1; after 3 more ticks, back to 0.
- Slot 2 running, slots 0 and 3 ready → expiry selects 3, then 0 (wrap-around order 3, 0, 2).
- `end_program` on the only ready slot → no `save_req`, `idle`=1; `start_prog` id 1 → SELECT, `load_req`, `cur_prog`=1.
- `end_program` and expiry tick in the same cycle with 2 slots ready → no `save_req`, ready bit cleared, `load_req` for the other slot.
- `def_quantum`=5 mid-quantum, then `quantum_value`=0 → current count unchanged, next slice 5 ticks, following slice 1 tick; reset asserted during SAVE clears `save_req` immediately.
